// File: rtl/ones_count_pkg.sv
// Shared types and helpers for the ones-count expander and related decoders:
// FSM state encoding, count clamping and thermometer expansion.
package ones_count_pkg;

    localparam int MaxN = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clamp_count(input int count, input int n);
        return (count > n) ? n : count;
    endfunction

    // Widest supported word; callers size-cast the result down to their own N.
    function automatic logic [MaxN-1:0] to_therm(input int count, input int n);
        logic [MaxN-1:0] t;
        int c;
        c = clamp_count(count, n);
        t = '0;
        for (int i = 0; i < MaxN; i++) begin
            t[i] = (i < c);
        end
        return t;
    endfunction

endpackage

// File: rtl/count_to_therm.sv
// Combinational count-to-thermometer decoder: clamps the count to N and
// flags counts that needed clamping.
module count_to_therm
    import ones_count_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [CW-1:0] count_i,
    output logic [N-1:0]  therm_o,
    output logic          ovf_o
);

    assign therm_o = N'(to_therm(int'(count_i), N));
    assign ovf_o   = (int'(count_i) > N);

endmodule

// File: rtl/ones_count_expander.sv
// Expands a ones-count into a thermometer word and streams it out LSB first.
// Define ONES_EXPANDER_B2B_EN to accept the next count on the last beat (no bubble).
module ones_count_expander
    import ones_count_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic          out_last,
    output logic [N-1:0]  therm,
    output logic          busy,
    output logic          ovf
);

`ifdef ONES_EXPANDER_B2B_EN
    localparam bit B2bEn = 1'b1;
`else
    localparam bit B2bEn = 1'b0;
`endif

    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  therm_q, therm_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] idx_q, idx_d;

    logic [N-1:0]  newTherm;
    logic          newOvf;

    count_to_therm #(
        .N  (N),
        .CW (CW)
    ) u_decode (
        .count_i (in_count),
        .therm_o (newTherm),
        .ovf_o   (newOvf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            therm_q <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            therm_q <= therm_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    // A capture overrides the shift update, which is what lets the
    // back-to-back build reload on the final beat and stay in SHIFT.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        therm_d   = therm_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_bit   = shift_q[0];
                out_last  = (idx_q == LastIdx);
                if (out_ready) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + CW'(1);
                    if (out_last) begin
                        state_d  = IDLE;
                        in_ready = B2bEn;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_valid && in_ready) begin
            therm_d = newTherm;
            shift_d = newTherm;
            ovf_d   = newOvf;
            idx_d   = '0;
            state_d = SHIFT;
        end
    end

    assign therm = therm_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_ones_count_expander.sv
// Directed self-checking bench for ones_count_expander at N=3 and N=5,
// covering back-to-back behaviour for either ONES_EXPANDER_B2B_EN setting.
module tb_ones_count_expander;

`ifdef ONES_EXPANDER_B2B_EN
    localparam bit B2b = 1'b1;
`else
    localparam bit B2b = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       inValid3 = 1'b0;
    logic       inReady3;
    logic [1:0] inCount3 = '0;
    logic       outValid3;
    logic       outReady3 = 1'b1;
    logic       outBit3;
    logic       outLast3;
    logic [2:0] therm3;
    logic       busy3;
    logic       ovf3;

    logic       inValid5 = 1'b0;
    logic       inReady5;
    logic [2:0] inCount5 = '0;
    logic       outValid5;
    logic       outReady5 = 1'b1;
    logic       outBit5;
    logic       outLast5;
    logic [4:0] therm5;
    logic       busy5;
    logic       ovf5;

    int checks = 0;
    int errors = 0;
    int ones3 = 0;
    int beats3 = 0;
    int ones5 = 0;

    always #5 clk = ~clk;

    ones_count_expander #(.N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid3),
        .in_ready  (inReady3),
        .in_count  (inCount3),
        .out_valid (outValid3),
        .out_ready (outReady3),
        .out_bit   (outBit3),
        .out_last  (outLast3),
        .therm     (therm3),
        .busy      (busy3),
        .ovf       (ovf3)
    );

    ones_count_expander #(.N(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid5),
        .in_ready  (inReady5),
        .in_count  (inCount5),
        .out_valid (outValid5),
        .out_ready (outReady5),
        .out_bit   (outBit5),
        .out_last  (outLast5),
        .therm     (therm5),
        .busy      (busy5),
        .ovf       (ovf5)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus3(input logic [1:0] count);
        checkOutput("in_ready3_before_send", 32'(inReady3), 32'd1);
        inValid3 = 1'b1;
        inCount3 = count;
        tick();
        inValid3 = 1'b0;
        ones3 = 0;
        beats3 = 0;
    endtask

    task automatic applyStimulus5(input logic [2:0] count);
        checkOutput("in_ready5_before_send", 32'(inReady5), 32'd1);
        inValid5 = 1'b1;
        inCount5 = count;
        tick();
        inValid5 = 1'b0;
        ones5 = 0;
    endtask

    task automatic expectBeat3(input string tag, input logic expBit, input logic expLast);
        checkOutput({tag, ".valid"}, 32'(outValid3), 32'd1);
        checkOutput({tag, ".bit"},   32'(outBit3),   32'(expBit));
        checkOutput({tag, ".last"},  32'(outLast3),  32'(expLast));
        checkOutput({tag, ".busy"},  32'(busy3),     32'd1);
        if (outValid3 && outReady3) begin
            ones3 += int'(outBit3);
            beats3++;
        end
        tick();
    endtask

    task automatic expectBeat5(input string tag, input logic expBit, input logic expLast);
        checkOutput({tag, ".valid"}, 32'(outValid5), 32'd1);
        checkOutput({tag, ".bit"},   32'(outBit5),   32'(expBit));
        checkOutput({tag, ".last"},  32'(outLast5),  32'(expLast));
        if (outValid5 && outReady5) begin
            ones5 += int'(outBit5);
        end
        tick();
    endtask

    task automatic expectIdle3(input string tag);
        checkOutput({tag, ".valid"},    32'(outValid3), 32'd0);
        checkOutput({tag, ".in_ready"}, 32'(inReady3),  32'd1);
        checkOutput({tag, ".busy"},     32'(busy3),     32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst.in_ready3",  32'(inReady3),  32'd1);
        checkOutput("rst.out_valid3", 32'(outValid3), 32'd0);
        checkOutput("rst.out_bit3",   32'(outBit3),   32'd0);
        checkOutput("rst.out_last3",  32'(outLast3),  32'd0);
        checkOutput("rst.therm3",     32'(therm3),    32'd0);
        checkOutput("rst.busy3",      32'(busy3),     32'd0);
        checkOutput("rst.ovf3",       32'(ovf3),      32'd0);
        checkOutput("rst.therm5",     32'(therm5),    32'd0);
        checkOutput("rst.in_ready5",  32'(inReady5),  32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // count 2: 1,1,0 with last on the third beat
        applyStimulus3(2'd2);
        checkOutput("t1.therm", 32'(therm3), 32'b011);
        checkOutput("t1.ovf", 32'(ovf3), 32'd0);
        checkOutput("t1.in_ready_busy", 32'(inReady3), 32'd0);
        expectBeat3("t1.b0", 1'b1, 1'b0);
        expectBeat3("t1.b1", 1'b1, 1'b0);
        expectBeat3("t1.b2", 1'b0, 1'b1);
        expectIdle3("t1.idle");
        checkOutput("t1.therm_held", 32'(therm3), 32'b011);
        checkOutput("t1.loop", 32'(ones3), 32'd2);

        // count 0 then count 3
        applyStimulus3(2'd0);
        checkOutput("t2a.therm", 32'(therm3), 32'b000);
        expectBeat3("t2a.b0", 1'b0, 1'b0);
        expectBeat3("t2a.b1", 1'b0, 1'b0);
        expectBeat3("t2a.b2", 1'b0, 1'b1);
        checkOutput("t2a.loop", 32'(ones3), 32'd0);
        expectIdle3("t2a.idle");
        applyStimulus3(2'd3);
        checkOutput("t2b.therm", 32'(therm3), 32'b111);
        checkOutput("t2b.ovf", 32'(ovf3), 32'd0);
        expectBeat3("t2b.b0", 1'b1, 1'b0);
        expectBeat3("t2b.b1", 1'b1, 1'b0);
        expectBeat3("t2b.b2", 1'b1, 1'b1);
        checkOutput("t2b.loop", 32'(ones3), 32'd3);
        expectIdle3("t2b.idle");

        // count 1 with two stalled cycles on beat 1
        applyStimulus3(2'd1);
        checkOutput("t3.therm", 32'(therm3), 32'b001);
        expectBeat3("t3.b0", 1'b1, 1'b0);
        outReady3 = 1'b0;
        expectBeat3("t3.stall0", 1'b0, 1'b0);
        expectBeat3("t3.stall1", 1'b0, 1'b0);
        outReady3 = 1'b1;
        expectBeat3("t3.b1", 1'b0, 1'b0);
        expectBeat3("t3.b2", 1'b0, 1'b1);
        checkOutput("t3.beats", 32'(beats3), 32'd3);
        checkOutput("t3.loop", 32'(ones3), 32'd1);
        expectIdle3("t3.idle");

        // N=5: an out-of-range count clamps and flags, a legal one clears the flag
        applyStimulus5(3'd7);
        checkOutput("t4a.therm", 32'(therm5), 32'b11111);
        checkOutput("t4a.ovf", 32'(ovf5), 32'd1);
        expectBeat5("t4a.b0", 1'b1, 1'b0);
        expectBeat5("t4a.b1", 1'b1, 1'b0);
        expectBeat5("t4a.b2", 1'b1, 1'b0);
        expectBeat5("t4a.b3", 1'b1, 1'b0);
        expectBeat5("t4a.b4", 1'b1, 1'b1);
        checkOutput("t4a.idle_valid", 32'(outValid5), 32'd0);
        checkOutput("t4a.ovf_held", 32'(ovf5), 32'd1);
        checkOutput("t4a.loop", 32'(ones5), 32'd5);
        applyStimulus5(3'd2);
        checkOutput("t4b.therm", 32'(therm5), 32'b00011);
        checkOutput("t4b.ovf", 32'(ovf5), 32'd0);
        expectBeat5("t4b.b0", 1'b1, 1'b0);
        expectBeat5("t4b.b1", 1'b1, 1'b0);
        expectBeat5("t4b.b2", 1'b0, 1'b0);
        expectBeat5("t4b.b3", 1'b0, 1'b0);
        expectBeat5("t4b.b4", 1'b0, 1'b1);
        checkOutput("t4b.loop", 32'(ones5), 32'd2);

        // asynchronous reset during beat 2 of count 3
        applyStimulus3(2'd3);
        expectBeat3("t5.b0", 1'b1, 1'b0);
        expectBeat3("t5.b1", 1'b1, 1'b0);
        checkOutput("t5.pre_valid", 32'(outValid3), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5.rst_valid", 32'(outValid3), 32'd0);
        checkOutput("t5.rst_therm", 32'(therm3), 32'd0);
        checkOutput("t5.rst_in_ready", 32'(inReady3), 32'd1);
        checkOutput("t5.rst_busy", 32'(busy3), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("t5.no_more_beats", 32'(outValid3), 32'd0);
        applyStimulus3(2'd1);
        expectBeat3("t5n.b0", 1'b1, 1'b0);
        expectBeat3("t5n.b1", 1'b0, 1'b0);
        expectBeat3("t5n.b2", 1'b0, 1'b1);
        checkOutput("t5n.loop", 32'(ones3), 32'd1);

        // counts 3 then 1 with the source holding the second count
        inValid3 = 1'b1;
        inCount3 = 2'd3;
        tick();
        inCount3 = 2'd1;
        ones3 = 0;
        checkOutput("t6a.therm", 32'(therm3), 32'b111);
        expectBeat3("t6a.b0", 1'b1, 1'b0);
        expectBeat3("t6a.b1", 1'b1, 1'b0);
        checkOutput("t6a.last_in_ready", 32'(inReady3), 32'(B2b));
        expectBeat3("t6a.b2", 1'b1, 1'b1);
        checkOutput("t6a.loop", 32'(ones3), 32'd3);
        if (!B2b) begin
            checkOutput("t6.gap_valid", 32'(outValid3), 32'd0);
            checkOutput("t6.gap_in_ready", 32'(inReady3), 32'd1);
            tick();
        end
        inValid3 = 1'b0;
        ones3 = 0;
        checkOutput("t6b.therm", 32'(therm3), 32'b001);
        expectBeat3("t6b.b0", 1'b1, 1'b0);
        expectBeat3("t6b.b1", 1'b0, 1'b0);
        expectBeat3("t6b.b2", 1'b0, 1'b1);
        checkOutput("t6b.loop", 32'(ones3), 32'd1);
        expectIdle3("t6b.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
